// File: rtl/vga_sync_if.sv
// Bundles the count enable and all decoded VGA timing outputs of vga_sync_generator.
// The generator connects through master; the pattern generator or bench connects through slave.
interface vga_sync_if;
    logic       enable;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_end;
    logic       frame_start;

    modport master (
        input  enable,
        output hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start
    );

    modport slave (
        output enable,
        input  hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start
    );
endinterface

// File: rtl/vga_sync_generator.sv
// VGA timing generator: pixel/line counters with registered sync, blanking and marker decode.
// Every output is decoded from the next counter values, so it matches the position shown with it.
module vga_sync_generator #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic        clock_in,
    input  logic        reset,
    vga_sync_if.master  bus
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HMax     = 10'(H_TOTAL - 1);
    localparam logic [9:0] VMax     = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVis     = 10'(H_VISIBLE);
    localparam logic [9:0] VVis     = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncLo  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HSyncHi  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VSyncLo  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VSyncHi  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       wrap;
    logic       hsync_q, vsync_q, video_on_q, line_end_q, frame_start_q;
    logic       hsync_d, vsync_d, video_on_d, line_end_d;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        wrap = 1'b0;
        if (x_q == HMax) begin
            x_d = '0;
            if (y_q == VMax) begin
                y_d  = '0;
                wrap = 1'b1;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
        end
    end

    always_comb begin
        video_on_d = (x_d < HVis) && (y_d < VVis);
        hsync_d    = ((x_d >= HSyncLo) && (x_d <= HSyncHi)) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = ((y_d >= VSyncLo) && (y_d <= VSyncHi)) ? SYNC_POL : ~SYNC_POL;
        line_end_d = (x_d == HMax);
    end

    // Disabled cycles hold everything, so a pulse seen when enable drops stays visible.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (bus.enable) begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= wrap;
        end
    end

    assign bus.pixel_x     = x_q;
    assign bus.pixel_y     = y_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_on_q;
    assign bus.line_end    = line_end_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench: a full-size 640x480 instance for reset and line timing, and a tiny
// active-high-sync instance (15x8) for frame wrap, enable hold and async reset.
module tb_vga_sync_generator;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    vga_sync_if if_a ();
    vga_sync_if if_b ();

    vga_sync_generator dut_a (
        .clock_in (clk),
        .reset    (rst_a),
        .bus      (if_a.master)
    );

    vga_sync_generator #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL  (1'b1)
    ) dut_b (
        .clock_in (clk),
        .reset    (rst_b),
        .bus      (if_b.master)
    );

    always #5 clk = ~clk;

    // Small-instance model: position, wrap flag, and "outputs still at reset values".
    int ex = 0, ey = 0;
    bit efs = 1'b0, fresh = 1'b1;

    task automatic adv_b();
        fresh = 1'b0;
        efs   = 1'b0;
        if (ex == 14) begin
            ex = 0;
            if (ey == 7) begin
                ey  = 0;
                efs = 1'b1;
            end else begin
                ey = ey + 1;
            end
        end else begin
            ex = ex + 1;
        end
    endtask

    // Packed as {hsync, vsync, video_on, line_end, frame_start, pixel_x, pixel_y}.
    function automatic logic [24:0] exp_b();
        logic hs, vs, vo, le;
        if (fresh) return {5'b00000, 10'd0, 10'd0};
        vo = (ex < 8) && (ey < 4);
        hs = (ex >= 10) && (ex <= 12);
        vs = (ey >= 5) && (ey <= 6);
        le = (ex == 14);
        return {hs, vs, vo, le, efs, 10'(ex), 10'(ey)};
    endfunction

    function automatic logic [24:0] obs_b();
        return {if_b.hsync, if_b.vsync, if_b.video_on, if_b.line_end, if_b.frame_start,
                if_b.pixel_x, if_b.pixel_y};
    endfunction

    task automatic test_reset();
        logic [14:0] obs;
        rst_a = 1'b1;
        if_a.enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {if_a.hsync, if_a.vsync, if_a.video_on, if_a.line_end, if_a.frame_start,
               if_a.pixel_x};
        n_vec++;
        if (obs !== {5'b11000, 10'd0} || if_a.pixel_y !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b y=%0d, want %b y=0", obs, if_a.pixel_y,
                     {5'b11000, 10'd0});
        end
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (if_a.pixel_x !== 10'(i) || if_a.pixel_y !== 10'd0 || if_a.video_on !== 1'b1) begin
                n_err++;
                $display("FAIL release_step%0d: got x=%0d y=%0d vo=%b, want x=%0d y=0 vo=1",
                         i, if_a.pixel_x, if_a.pixel_y, if_a.video_on, i);
            end
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        logic [12:0] want, got;
        for (int x = 4; x <= 799; x++) begin
            @(posedge clk);
            @(negedge clk);
            want = {10'(x), (x < 640) ? 1'b1 : 1'b0, (x >= 656 && x <= 751) ? 1'b0 : 1'b1,
                    (x == 799) ? 1'b1 : 1'b0};
            got  = {if_a.pixel_x, if_a.video_on, if_a.hsync, if_a.line_end};
            if (if_a.hsync === 1'b0) hs_low++;
            n_vec++;
            if (got !== want || if_a.pixel_y !== 10'd0 || if_a.vsync !== 1'b1) begin
                n_err++;
                $display("FAIL line_x%0d: got {x,vo,hs,le}=%h y=%0d vs=%b, want %h y=0 vs=1",
                         x, got, if_a.pixel_y, if_a.vsync, want);
            end
        end
        n_vec++;
        if (hs_low != 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d, want 96", hs_low);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (if_a.pixel_x !== 10'd0 || if_a.pixel_y !== 10'd1 || if_a.video_on !== 1'b1 ||
            if_a.line_end !== 1'b0 || if_a.frame_start !== 1'b0 || if_a.hsync !== 1'b1) begin
            n_err++;
            $display("FAIL line_wrap: got x=%0d y=%0d vo=%b le=%b fs=%b hs=%b, want 0 1 1 0 0 1",
                     if_a.pixel_x, if_a.pixel_y, if_a.video_on, if_a.line_end,
                     if_a.frame_start, if_a.hsync);
        end
    endtask

    task automatic test_frame();
        int fs_cnt = 0, vs_cnt = 0, fs_first = -1, fs_last = -1;
        rst_b = 1'b1;
        if_b.enable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ex = 0; ey = 0; efs = 1'b0; fresh = 1'b1;
        n_vec++;
        if (obs_b() !== exp_b()) begin
            n_err++;
            $display("FAIL frame_reset: got %h, want %h", obs_b(), exp_b());
        end
        rst_b = 1'b0;
        for (int c = 1; c <= 240; c++) begin
            @(posedge clk);
            adv_b();
            @(negedge clk);
            if (if_b.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                fs_last = c;
            end
            if (if_b.vsync === 1'b1) vs_cnt++;
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_err++;
                $display("FAIL frame_cycle%0d: got %h, want %h", c, obs_b(), exp_b());
            end
        end
        n_vec++;
        if (fs_cnt != 2 || fs_first != 120 || fs_last != 240) begin
            n_err++;
            $display("FAIL frame_period: got cnt=%0d at %0d,%0d, want cnt=2 at 120,240",
                     fs_cnt, fs_first, fs_last);
        end
        n_vec++;
        if (vs_cnt != 60) begin
            n_err++;
            $display("FAIL vsync_width: got %0d, want 60", vs_cnt);
        end
    endtask

    task automatic test_enable_hold();
        int guard = 0;
        logic [24:0] frozen;
        while (!(ex == 11 && ey == 2) && guard < 200) begin
            @(posedge clk);
            adv_b();
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (obs_b() !== exp_b() || guard >= 200) begin
            n_err++;
            $display("FAIL hold_reach: got %h, want %h (guard %0d)", obs_b(), exp_b(), guard);
        end
        frozen = exp_b();
        if_b.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (obs_b() !== frozen || if_b.hsync !== 1'b1) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got %h, want %h", i, obs_b(), frozen);
            end
        end
        if_b.enable = 1'b1;
        @(posedge clk);
        adv_b();
        @(negedge clk);
        n_vec++;
        if (obs_b() !== exp_b() || if_b.pixel_x !== 10'd12) begin
            n_err++;
            $display("FAIL hold_resume: got %h, want %h", obs_b(), exp_b());
        end
    endtask

    task automatic test_async_reset();
        while (!(ex == 5 && ey == 3)) begin
            @(posedge clk);
            adv_b();
            @(negedge clk);
        end
        @(posedge clk);
        adv_b();
        #2 rst_b = 1'b1;
        #1;
        ex = 0; ey = 0; efs = 1'b0; fresh = 1'b1;
        n_vec++;
        if (obs_b() !== exp_b()) begin
            n_err++;
            $display("FAIL async_reset: got %h, want %h", obs_b(), exp_b());
        end
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            adv_b();
            @(negedge clk);
            n_vec++;
            if (obs_b() !== exp_b() || if_b.video_on !== 1'b1) begin
                n_err++;
                $display("FAIL async_recover%0d: got %h, want %h", i, obs_b(), exp_b());
            end
        end
    endtask

    initial begin
        if_a.enable = 1'b1;
        if_b.enable = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_enable_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
